// File: rtl/niosii_system_sysid_checker.sv
`default_nettype none
// ============================================================================
//  Module   : niosii_system_sysid_checker
//  Brief    : Avalon-MM master that reads the system ID (word 0) and build
//             timestamp (word 1) from the sysid slave, compares both against
//             expected constants and reports match / mismatch / timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module niosii_system_sysid_checker #(
    parameter logic [31:0] EXP_ID  = 32'd0,
    parameter logic [31:0] EXP_TS  = 32'd1487455193,
    parameter logic [15:0] TIMEOUT = 16'd255        // must be >= 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout_err,
    output logic [31:0] sys_id,
    output logic [31:0] sys_ts
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_id_req  = 3'd1;
    localparam logic [2:0] c_st_id_wait = 3'd2;
    localparam logic [2:0] c_st_ts_req  = 3'd3;
    localparam logic [2:0] c_st_ts_wait = 3'd4;
    localparam logic [2:0] c_st_done    = 3'd5;

    localparam logic [15:0] c_tmo_last = TIMEOUT - 16'd1;

    logic [2:0]  r_state;
    logic        r_avm_read;
    logic        r_avm_address;
    logic        r_busy;
    logic        r_done;
    logic        r_id_match;
    logic        r_ts_match;
    logic        r_timeout_err;
    logic [31:0] r_sys_id;
    logic [31:0] r_sys_ts;
    logic [15:0] r_tmo_cnt;

    logic        w_accept;
    logic        w_expired;

    // A request is taken by the slave when read is high and it is not stalling;
    // the budget is spent once the counter sits on its last allowed value.
    assign w_accept  = r_avm_read & ~avm_waitrequest;
    assign w_expired = (r_tmo_cnt == c_tmo_last);

    // Sequencer: two back-to-back reads, capture, compare, report.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_avm_read    <= 1'b0;
            r_avm_address <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_id_match    <= 1'b0;
            r_ts_match    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_sys_id      <= 32'd0;
            r_sys_ts      <= 32'd0;
            r_tmo_cnt     <= 16'd0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_state       <= c_st_id_req;
                        r_avm_read    <= 1'b1;
                        r_avm_address <= 1'b0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_id_match    <= 1'b0;
                        r_ts_match    <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_sys_id      <= 32'd0;
                        r_sys_ts      <= 32'd0;
                        r_tmo_cnt     <= 16'd0;
                    end
                end

                // The transaction only completes on readdatavalid, so an
                // exhausted budget in a REQ state aborts even if the slave
                // happens to accept on that same edge.
                c_st_id_req, c_st_ts_req: begin
                    if (w_expired) begin
                        r_state       <= c_st_done;
                        r_avm_read    <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_id_match    <= 1'b0;
                        r_ts_match    <= 1'b0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                        if (w_accept) begin
                            r_avm_read <= 1'b0;
                            r_state    <= (r_state == c_st_id_req) ? c_st_id_wait
                                                                   : c_st_ts_wait;
                        end
                    end
                end

                c_st_id_wait: begin
                    if (avm_readdatavalid) begin
                        r_sys_id      <= avm_readdata;
                        r_state       <= c_st_ts_req;
                        r_avm_read    <= 1'b1;
                        r_avm_address <= 1'b1;
                        r_tmo_cnt     <= 16'd0;
                    end else if (w_expired) begin
                        r_state       <= c_st_done;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_id_match    <= 1'b0;
                        r_ts_match    <= 1'b0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end

                // The timestamp is compared straight off the bus since the
                // captured copy only becomes visible after this edge.
                c_st_ts_wait: begin
                    if (avm_readdatavalid) begin
                        r_sys_ts      <= avm_readdata;
                        r_state       <= c_st_done;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_id_match    <= (r_sys_id == EXP_ID);
                        r_ts_match    <= (avm_readdata == EXP_TS);
                    end else if (w_expired) begin
                        r_state       <= c_st_done;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_id_match    <= 1'b0;
                        r_ts_match    <= 1'b0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state    <= c_st_idle;
                    r_avm_read <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address = r_avm_address;
    assign avm_read    = r_avm_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign id_match    = r_id_match;
    assign ts_match    = r_ts_match;
    assign timeout_err = r_timeout_err;
    assign sys_id      = r_sys_id;
    assign sys_ts      = r_sys_ts;

endmodule
`default_nettype wire

// File: tb/tb_niosii_system_sysid_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_niosii_system_sysid_checker
//  Brief    : Scoreboard bench for the sysid checker with a configurable
//             Avalon slave (stall cycles, readdatavalid delay, data words).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_niosii_system_sysid_checker;

    localparam logic [31:0] c_exp_id = 32'd0;
    localparam logic [31:0] c_exp_ts = 32'd1487455193;
    localparam int          c_tmo    = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy;
    logic        done;
    logic        id_match;
    logic        ts_match;
    logic        timeout_err;
    logic [31:0] sys_id;
    logic [31:0] sys_ts;

    niosii_system_sysid_checker #(
        .EXP_ID (c_exp_id),
        .EXP_TS (c_exp_ts),
        .TIMEOUT(16'(c_tmo))
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy             (busy),
        .done             (done),
        .id_match         (id_match),
        .ts_match         (ts_match),
        .timeout_err      (timeout_err),
        .sys_id           (sys_id),
        .sys_ts           (sys_ts)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          lat;        // start cycle = 0, done visible in cycle lat
        logic        tmo;
        logic        idm;
        logic        tsm;
        logic [31:0] sid;
        logic [31:0] sts;
        int          acc;
        int          start_edge;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    // slave configuration per word address; d == 0 means never answer
    int          cfg_w[2];
    int          cfg_d[2];
    logic [31:0] cfg_data[2];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, act, act, req, req);
        end
    endtask

    // Reference: a transaction of w stall cycles and data after d wait cycles
    // occupies w+1+d cycles and must fit in the timeout budget.
    function automatic exp_t model(input int w0, input int d0, input int w1, input int d1,
                                   input logic [31:0] x0, input logic [31:0] x1);
        exp_t e;
        int   t0;
        int   t1;
        t0 = (d0 == 0) ? 1000 : w0 + 1 + d0;
        t1 = (d1 == 0) ? 1000 : w1 + 1 + d1;
        e.tmo = 1'b0; e.idm = 1'b0; e.tsm = 1'b0;
        e.sid = 32'd0; e.sts = 32'd0; e.start_edge = 0;
        e.acc = (w0 + 1 <= c_tmo) ? 1 : 0;
        if (t0 > c_tmo) begin
            e.lat = 1 + c_tmo;
            e.tmo = 1'b1;
        end else begin
            e.sid = x0;
            e.acc += (w1 + 1 <= c_tmo) ? 1 : 0;
            if (t1 > c_tmo) begin
                e.lat = 1 + t0 + c_tmo;
                e.tmo = 1'b1;
            end else begin
                e.lat = 1 + t0 + t1;
                e.sts = x1;
                e.idm = (x0 == c_exp_id);
                e.tsm = (x1 == c_exp_ts);
            end
        end
        return e;
    endfunction

    // Slave model: stalls, delayed readdatavalid, and stray readdatavalid
    // pulses whenever the master is not waiting for data.
    initial begin
        int          stall_left;
        int          rdv_left;
        bit          in_req;
        bit          pend;
        logic        req_addr;
        logic        pend_addr;
        bit          real_rdv;
        logic [31:0] real_data;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        in_req = 0; pend = 0; stall_left = 0; rdv_left = 0;
        req_addr = 1'b0; pend_addr = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                in_req = 0; pend = 0;
                avm_waitrequest   = 1'b0;
                avm_readdatavalid = 1'b0;
            end else begin
                real_rdv  = 0;
                real_data = 32'd0;
                if (pend) begin
                    rdv_left--;
                    if (rdv_left == 0) begin
                        pend      = 0;
                        real_rdv  = 1;
                        real_data = cfg_data[pend_addr];
                    end
                end
                if (avm_read) begin
                    if (!in_req) begin
                        in_req     = 1;
                        req_addr   = avm_address;
                        stall_left = cfg_w[avm_address];
                    end else begin
                        check("addr_stable", {31'd0, avm_address}, {31'd0, req_addr});
                    end
                    if (stall_left != 0) begin
                        avm_waitrequest = 1'b1;
                        stall_left--;
                    end else begin
                        avm_waitrequest = 1'b0;
                        in_req = 0;
                        if (cfg_d[req_addr] != 0) begin
                            pend      = 1;
                            rdv_left  = cfg_d[req_addr];
                            pend_addr = req_addr;
                        end
                    end
                end else begin
                    in_req = 0;
                    avm_waitrequest = 1'($urandom_range(0, 1));
                end
                if (real_rdv) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = real_data;
                end else if ((!busy || avm_read) && $urandom_range(0, 3) == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = $urandom;
                end else begin
                    avm_readdatavalid = 1'b0;
                    avm_readdata      = $urandom;
                end
            end
        end
    end

    // Monitor: on each rising done, pop the oldest expectation and compare.
    initial begin
        logic prev_done;
        int   acc;
        exp_t e;
        prev_done = 1'b0;
        acc = 0;
        forever begin
            @(negedge clock);
            if (avm_read && !avm_waitrequest) acc++;
            if (!busy && !done) acc = 0;
            if (done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending sequence");
                end else begin
                    e = exp_q.pop_front();
                    check("latency",     32'(cyc - e.start_edge + 1), 32'(e.lat));
                    check("timeout_err", {31'd0, timeout_err}, {31'd0, e.tmo});
                    check("id_match",    {31'd0, id_match},    {31'd0, e.idm});
                    check("ts_match",    {31'd0, ts_match},    {31'd0, e.tsm});
                    check("sys_id",      sys_id, e.sid);
                    check("sys_ts",      sys_ts, e.sts);
                    check("accepts",     32'(acc), 32'(e.acc));
                    check("done_rd_busy", {30'd0, avm_read, busy}, 32'd0);
                end
                acc = 0;
            end
            prev_done = done;
        end
    end

    task automatic check_all_zero(input string nm);
        check(nm, {25'd0, busy, done, avm_read, avm_address, id_match, ts_match, timeout_err}, 32'd0);
        check({nm, "_id"}, sys_id, 32'd0);
        check({nm, "_ts"}, sys_ts, 32'd0);
    endtask

    task automatic run_seq(input int w0, input int d0, input int w1, input int d1,
                           input logic [31:0] x0, input logic [31:0] x1, input bit extra);
        exp_t e;
        cfg_w[0] = w0; cfg_d[0] = d0; cfg_data[0] = x0;
        cfg_w[1] = w1; cfg_d[1] = d1; cfg_data[1] = x1;
        e = model(w0, d0, w1, d1, x0, x1);
        @(negedge clock);
        e.start_edge = cyc + 1;
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_state", {27'd0, busy, done, id_match, ts_match, timeout_err}, 32'b10000);
        check("start_clr_id", sys_id, 32'd0);
        if (extra) begin
            @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clock);
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL seq_wait: got no done within 300 cycles expected done");
            exp_q.delete();
        end
        repeat (15) @(negedge clock);
        check("hold_done", {29'd0, done, busy, avm_read}, 32'b100);
        check("hold_flags", {29'd0, id_match, ts_match, timeout_err}, {29'd0, e.idm, e.tsm, e.tmo});
        check("hold_id", sys_id, e.sid);
        check("hold_ts", sys_ts, e.sts);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w0, d0, w1, d1;
        logic [31:0] x0, x1;
        cfg_w[0] = 0; cfg_w[1] = 0; cfg_d[0] = 1; cfg_d[1] = 1;
        cfg_data[0] = c_exp_id; cfg_data[1] = c_exp_ts;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_all_zero("reset_state");

        // ideal slave, both words correct; then timestamp off by one
        run_seq(0, 1, 0, 1, c_exp_id, c_exp_ts, 0);
        run_seq(0, 1, 0, 1, c_exp_id, c_exp_ts + 32'd1, 0);
        // three stall cycles per request
        run_seq(3, 1, 3, 1, c_exp_id, c_exp_ts, 0);
        // timestamp never returned
        run_seq(0, 1, 0, 0, c_exp_id, c_exp_ts, 0);
        // exact budget fits, one more cycle does not
        run_seq(2, 5, 0, 1, c_exp_id, c_exp_ts, 0);
        run_seq(2, 6, 0, 1, c_exp_id, c_exp_ts, 0);
        run_seq(0, 1, 7, 1, 32'h1234_5678, c_exp_ts, 0);

        // reset while waiting for the ID word
        cfg_w[0] = 0; cfg_d[0] = 1; cfg_data[0] = 32'hDEAD_BEEF;
        cfg_w[1] = 0; cfg_d[1] = 1; cfg_data[1] = c_exp_ts;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_all_zero("mid_reset");
        repeat (10) @(negedge clock);
        run_seq(0, 1, 0, 1, c_exp_id, c_exp_ts, 0);

        // extra start while busy, then a rerun from DONE
        run_seq(3, 2, 3, 2, c_exp_id, c_exp_ts, 1);
        run_seq(3, 2, 3, 2, c_exp_id, c_exp_ts, 0);

        // start and reset together: reset wins
        @(negedge clock);
        start = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        start = 1'b0;
        reset = 1'b0;
        check_all_zero("start_reset");

        // randomized sequences
        for (int i = 0; i < 30; i++) begin
            w0 = $urandom_range(0, 6);
            d0 = $urandom_range(0, 6);
            w1 = $urandom_range(0, 6);
            d1 = $urandom_range(0, 6);
            x0 = ($urandom_range(0, 1) == 0) ? c_exp_id : 32'($urandom);
            case ($urandom_range(0, 2))
                0:       x1 = c_exp_ts;
                1:       x1 = c_exp_ts + 32'd1;
                default: x1 = 32'($urandom);
            endcase
            run_seq(w0, d0, w1, d1, x0, x1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
